mlp_98_framer: RTL and testbench
================================

# mlp_98_framer

Input-side framer for the 98-input denoiser MLP. It accepts a serial stream of signed samples and splits each sample into sign-magnitude form. It keeps a sliding window of N1/2 samples and drives the MLP's `in_mag`/`in_pol` buses with a one-cycle `frame_valid` strobe. A latency-matched `y_valid` marks the cycle the MLP's `out` holds that frame's result.

## Interface
- `N1`, 98: MLP input count; window depth is N1/2 (49).
- `W_X`, 4: magnitude width per sample.
- `W_S`, W_X+1: signed input sample width.
- `STRIDE`, 1: accepted samples between successive frames once the window is full; must be ≥1.
- `LAT`, 12: MLP pipeline latency from the input capture edge to `out` valid.
- `W_IDX`, 8: frame index counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1: `s_data` is valid this cycle and is accepted unconditionally.
- `s_data` in W_S: signed two's-complement sample.
- `flush` in 1: clears the window and restarts the fill.
- `in_mag` out [N1/2][W_X]: window magnitudes; index N1/2-1 is newest, 0 is oldest.
- `in_pol` out [N1/2]: window signs; 1 means negative.
- `frame_valid` out 1: one-cycle strobe; the current window is a frame.
- `frame_idx` out W_IDX: index of the frame flagged by `frame_valid`.
- `y_valid` out 1: the MLP `out` holds a frame result this cycle.

## Operation
- Sign-magnitude conversion: `pol = s_data[W_S-1]`, `mag = |s_data|`.
  - Zero gives mag 0, pol 0.
  - The most-negative value is handled per Configuration.
- On an accept (`s_valid` high and `flush` low), the window shifts toward index 0 and the new sample enters at index N1/2-1.
- States:
  - FILL: counts accepts in `fill_cnt` (0..N1/2-1). The accept that makes the count reach N1/2 raises `frame_valid` and moves to RUN.
  - RUN: `stride_cnt` counts accepts. The STRIDE-th accept after the previous frame raises `frame_valid` and resets `stride_cnt` to 0.
  - With STRIDE=1, every accept in RUN produces a frame.
- `frame_idx` starts at 0 after reset, increments after each frame, and wraps modulo 2^W_IDX.
- `flush` zeroes the window, zeroes `fill_cnt` and `stride_cnt`, and returns to FILL.
  - `frame_idx` is kept.
  - The `y_valid` pipeline is not cleared, so in-flight frames still complete.
- `flush` and `s_valid` in the same cycle: flush wins and the sample is dropped.
- Cycles without `s_valid`: window, counters and outputs are held; no frame is produced.
- Reset clears everything:
  - `in_mag`, `in_pol`, `frame_valid`, `frame_idx` and `y_valid` are 0.
  - State is FILL and the `y_valid` shift register is zeroed, so pending results are dropped.

## Timing
- All outputs are registered.
- `in_mag`/`in_pol` update on the edge that follows an accepting cycle.
- `frame_valid` is high in the cycle after the completing accept, aligned with the updated window.
  - The MLP captures that window on the closing edge of this cycle.
- `y_valid` is high exactly LAT cycles after `frame_valid`, via a LAT-deep shift register.
- Back-to-back frames (STRIDE=1, continuous `s_valid`) give continuous `frame_valid` and, LAT cycles later, continuous `y_valid`.
- No backpressure: the MLP never stalls.

## Configuration
- `MLP_FRAMER_SATURATE_EN`:
  - Defined: magnitude 2^W_X (from -2^W_X) saturates to 2^W_X-1, e.g. -16 gives mag 15, pol 1.
  - Undefined: magnitude is truncated to W_X bits, e.g. -16 gives mag 0, pol 1.
  - All other values are identical in both builds.

## Structure
- Shared package `mlp_pkg`:
  - Constants N1, N2, W_X, W_K, D1, D2 and derived LAT = D1+D2+1.
  - The framer state enum.
  - A `sign_mag_t` struct {pol, mag}.
- Sub-module `sign_mag_split`: combinational converter containing the saturation option. One instance, on the input sample.

## Test plan
- Reset, then 49 accepts of +3: `frame_valid` is high the cycle after the 49th accept, with all `in_mag`=3, `in_pol`=0 and `frame_idx`=0. `y_valid` is high 12 cycles later.
- STRIDE=4, feed samples 1..60 with random `s_valid` gaps: frames follow accepts 49, 53 and 57. The window at frame 2 has `in_mag[48]`=53 and `in_mag[0]`=5.
- Sample -16, W_X=4:
  - With the macro: mag 15, pol 1.
  - Without it: mag 0, pol 1.
  - Sample -5 gives mag 5, pol 1 in both builds.
- `flush` after 30 accepts: no frame until 49 further accepts and the window starts all-zero. `flush` with `s_valid` in the same cycle drops that sample.
- W_IDX=2, STRIDE=1, continuous stream: `frame_idx` runs 0,1,2,3,0. `y_valid` is a contiguous run that starts 12 cycles after the first frame.
- `rst` asserted 5 cycles after a frame: that frame's `y_valid` never appears and all outputs read 0 on the following cycle.

Source files
------------

// File: rtl/mlp_pkg.sv
// mlp_pkg: shared constants, framer state and sign-magnitude type for the denoiser MLP.
package mlp_pkg;
    localparam int N1 = 98;
    localparam int N2 = 16;
    localparam int W_X = 4;
    localparam int W_K = 4;
    localparam int D1 = 6;
    localparam int D2 = 5;
    localparam int LAT = D1 + D2 + 1;
    typedef enum logic {FILL, RUN} framer_state_t;
    typedef struct packed {
        logic           pol;
        logic [W_X-1:0] mag;
    } sign_mag_t;
endpackage

// File: rtl/sign_mag_split.sv
// sign_mag_split: two's-complement sample to sign-magnitude.
// MLP_FRAMER_SATURATE_EN clamps the most-negative magnitude instead of truncating it.
module sign_mag_split
    import mlp_pkg::*;
#(
    parameter int W_X = mlp_pkg::W_X
) (
    input  logic [W_X:0]   i_data,
    output logic           o_pol,
    output logic [W_X-1:0] o_mag
);
    logic [W_X-1:0] w_neg;
    assign w_neg = ~i_data[W_X-1:0] + 1'b1;
    assign o_pol = i_data[W_X];
`ifdef MLP_FRAMER_SATURATE_EN
    // low bits all zero with the sign set is -2^W_X, whose magnitude does not fit
    assign o_mag = !o_pol ? i_data[W_X-1:0] : (i_data[W_X-1:0] == '0) ? '1 : w_neg;
`else
    assign o_mag = o_pol ? w_neg : i_data[W_X-1:0];
`endif
endmodule

// File: rtl/mlp_98_framer.sv
// mlp_98_framer: sliding-window framer feeding the 98-input MLP, with latency-matched y_valid.
// Optional macro MLP_FRAMER_SATURATE_EN (in sign_mag_split) saturates the most-negative sample.
module mlp_98_framer
    import mlp_pkg::*;
#(
    parameter int N1     = mlp_pkg::N1,
    parameter int W_X    = mlp_pkg::W_X,
    parameter int W_S    = W_X + 1,
    parameter int STRIDE = 1,
    parameter int LAT    = mlp_pkg::LAT,
    parameter int W_IDX  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    input  logic [W_S-1:0]              s_data,
    input  logic                        flush,
    output logic [N1/2-1:0][W_X-1:0]    in_mag,
    output logic [N1/2-1:0]             in_pol,
    output logic                        frame_valid,
    output logic [W_IDX-1:0]            frame_idx,
    output logic                        y_valid
);
    localparam int D = N1 / 2;
    localparam int W_F = $clog2(D);
    localparam int W_SC = $clog2(STRIDE) + 1;
    localparam logic [W_F-1:0] FILL_LAST = W_F'(D - 1);
    localparam logic [W_SC-1:0] STRIDE_LAST = W_SC'(STRIDE - 1);

    framer_state_t         r_state, w_state_nxt;
    logic [W_F-1:0]        r_fill_cnt, w_fill_nxt;
    logic [W_SC-1:0]       r_stride_cnt, w_stride_nxt;
    logic [D-1:0][W_X-1:0] r_mag;
    logic [D-1:0]          r_pol;
    logic                  r_frame_valid;
    logic [W_IDX-1:0]      r_frame_idx;
    logic [LAT-1:0]        r_yv_sr;
    logic                  w_frame, w_pol;
    logic [W_X-1:0]        w_mag;

    sign_mag_split #(.W_X(W_X)) u_split (
        .i_data (s_data),
        .o_pol  (w_pol),
        .o_mag  (w_mag)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_fill_nxt   = r_fill_cnt;
        w_stride_nxt = r_stride_cnt;
        w_frame      = 1'b0;
        if (flush) begin
            w_state_nxt  = FILL;
            w_fill_nxt   = '0;
            w_stride_nxt = '0;
        end else if (s_valid && r_state == FILL) begin
            w_frame     = (r_fill_cnt == FILL_LAST);
            w_fill_nxt  = w_frame ? '0 : r_fill_cnt + 1'b1;
            w_state_nxt = w_frame ? RUN : FILL;
        end else if (s_valid) begin
            w_frame      = (r_stride_cnt == STRIDE_LAST);
            w_stride_nxt = w_frame ? '0 : r_stride_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FILL;
            r_fill_cnt    <= '0;
            r_stride_cnt  <= '0;
            r_mag         <= '0;
            r_pol         <= '0;
            r_frame_valid <= 1'b0;
            r_frame_idx   <= '0;
            r_yv_sr       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_fill_cnt    <= w_fill_nxt;
            r_stride_cnt  <= w_stride_nxt;
            r_frame_valid <= w_frame;
            r_frame_idx   <= r_frame_idx + W_IDX'(r_frame_valid);
            // flush leaves this pipeline alone so frames already handed to the MLP still report
            r_yv_sr       <= {r_yv_sr[LAT-2:0], r_frame_valid};
            if (flush) begin
                r_mag <= '0;
                r_pol <= '0;
            end else if (s_valid) begin
                r_mag <= {w_mag, r_mag[D-1:1]};
                r_pol <= {w_pol, r_pol[D-1:1]};
            end
        end
    end

    assign in_mag      = r_mag;
    assign in_pol      = r_pol;
    assign frame_valid = r_frame_valid;
    assign frame_idx   = r_frame_idx;
    assign y_valid     = r_yv_sr[LAT-1];
endmodule

// File: tb/tb_mlp_98_framer.sv
// tb_mlp_98_framer: three framer configurations on one stream, checked against a window/accept-count model.
module tb_mlp_98_framer;
    localparam int D = 49;
    localparam int M16 =
`ifdef MLP_FRAMER_SATURATE_EN
        15;
`else
        0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush, s_valid;
    logic [6:0] sdat;
    logic [D-1:0][3:0] mag_a, mag_c;
    logic [D-1:0][5:0] mag_b;
    logic [D-1:0] pol_a, pol_b, pol_c;
    logic fv_a, fv_b, fv_c, yv_a, yv_b, yv_c;
    logic [7:0] fi_a, fi_b;
    logic [1:0] fi_c;

    mlp_98_framer u_a (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(sdat[4:0]), .flush(flush),
        .in_mag(mag_a), .in_pol(pol_a), .frame_valid(fv_a), .frame_idx(fi_a), .y_valid(yv_a)
    );
    mlp_98_framer #(.W_X(6), .STRIDE(4)) u_b (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(sdat), .flush(flush),
        .in_mag(mag_b), .in_pol(pol_b), .frame_valid(fv_b), .frame_idx(fi_b), .y_valid(yv_b)
    );
    mlp_98_framer #(.W_IDX(2)) u_c (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(sdat[4:0]), .flush(flush),
        .in_mag(mag_c), .in_pol(pol_c), .frame_valid(fv_c), .frame_idx(fi_c), .y_valid(yv_c)
    );

    int stride_c[3] = '{1, 4, 1};
    int wx_c[3] = '{4, 6, 4};
    int imod[3] = '{256, 256, 4};
    int win[3][D];
    int acc[3];
    int fidx[3];
    bit fv[3];
    bit frame_at[3][8192];
    int cyc = 0;
    int last_rst = 0;
    int n_pass = 0;
    int n_chk = 0;

    function automatic int sval(int c);
        int w = wx_c[c] + 1;
        int v = int'(sdat) & ((1 << w) - 1);
        return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
    endfunction

    function automatic int emag(int c, int v);
        int a = (v < 0) ? -v : v;
        int top = 1 << wx_c[c];
`ifdef MLP_FRAMER_SATURATE_EN
        return (a >= top) ? top - 1 : a;
`else
        return a % top;
`endif
    endfunction

    task automatic model_update();
        cyc++;
        for (int c = 0; c < 3; c++) begin
            bit nf = 1'b0;
            if (rst) begin
                for (int i = 0; i < D; i++) win[c][i] = 0;
                acc[c] = 0;
                fidx[c] = 0;
                last_rst = cyc;
            end else begin
                if (fv[c]) fidx[c] = (fidx[c] + 1) % imod[c];
                if (flush) begin
                    for (int i = 0; i < D; i++) win[c][i] = 0;
                    acc[c] = 0;
                end else if (s_valid) begin
                    for (int i = 0; i < D - 1; i++) win[c][i] = win[c][i + 1];
                    win[c][D - 1] = sval(c);
                    acc[c]++;
                    nf = (acc[c] >= D) && ((acc[c] - D) % stride_c[c] == 0);
                end
            end
            fv[c] = nf;
            frame_at[c][cyc] = nf;
        end
    endtask

    task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic check_all();
        for (int c = 0; c < 3; c++) begin
            logic [511:0] em, ep, am, ap, af, ai, ay;
            bit ey;
            em = '0;
            ep = '0;
            for (int i = 0; i < D; i++) begin
                int m = emag(c, win[c][i]);
                for (int b = 0; b < wx_c[c]; b++) em[i * wx_c[c] + b] = m[b];
                ep[i] = win[c][i] < 0;
            end
            am = (c == 0) ? 512'(mag_a) : (c == 1) ? 512'(mag_b) : 512'(mag_c);
            ap = (c == 0) ? 512'(pol_a) : (c == 1) ? 512'(pol_b) : 512'(pol_c);
            af = (c == 0) ? 512'(fv_a) : (c == 1) ? 512'(fv_b) : 512'(fv_c);
            ai = (c == 0) ? 512'(fi_a) : (c == 1) ? 512'(fi_b) : 512'(fi_c);
            ay = (c == 0) ? 512'(yv_a) : (c == 1) ? 512'(yv_b) : 512'(yv_c);
            ey = (cyc > 12) && frame_at[c][cyc - 12] && (last_rst < cyc - 12);
            chk($sformatf("cfg%0d cyc%0d in_mag", c, cyc), am, em);
            chk($sformatf("cfg%0d cyc%0d in_pol", c, cyc), ap, ep);
            chk($sformatf("cfg%0d cyc%0d frame_valid", c, cyc), af, 512'(fv[c]));
            chk($sformatf("cfg%0d cyc%0d frame_idx", c, cyc), ai, 512'(fidx[c]));
            chk($sformatf("cfg%0d cyc%0d y_valid", c, cyc), ay, 512'(ey));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(bit r, bit f, bit v, int d);
        rst = r;
        flush = f;
        s_valid = v;
        sdat = 7'(d);
        tick();
    endtask

    typedef struct {
        int d;
        int mag;
        bit pol;
    } vec_t;
    vec_t tbl[8];

    initial begin
        tbl[0] = '{-16, M16, 1'b1};
        tbl[1] = '{-5, 5, 1'b1};
        tbl[2] = '{0, 0, 1'b0};
        tbl[3] = '{7, 7, 1'b0};
        tbl[4] = '{15, 15, 1'b0};
        tbl[5] = '{-1, 1, 1'b1};
        tbl[6] = '{-15, 15, 1'b1};
        tbl[7] = '{1, 1, 1'b0};
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; sdat = '0;
        repeat (3) drive(1, 0, 0, 0);
        chk("reset mag", 512'(mag_a), '0);
        chk("reset pol", 512'(pol_a), '0);
        chk("reset fv", 512'(fv_a), '0);
        chk("reset idx", 512'(fi_a), '0);
        chk("reset yv", 512'(yv_a), '0);

        repeat (D) drive(0, 0, 1, 3);
        chk("fill fv", 512'(fv_a), 512'(1));
        chk("fill idx", 512'(fi_a), '0);
        chk("fill mag", 512'(mag_a), 512'({49{4'd3}}));
        chk("fill pol", 512'(pol_a), '0);
        repeat (11) drive(0, 0, 0, 0);
        chk("fill y early", 512'(yv_a), '0);
        drive(0, 0, 0, 0);
        chk("fill y", 512'(yv_a), 512'(1));

        drive(1, 0, 0, 0);
        for (int i = 1; i <= 60; i++) begin
            repeat ($urandom_range(0, 2)) drive(0, 0, 0, 0);
            drive(0, 0, 1, i);
            if (i == 52) chk("stride no frame", 512'(fv_b), '0);
            if (i == 53) begin
                chk("stride fv", 512'(fv_b), 512'(1));
                chk("stride newest", 512'(mag_b[48]), 512'(53));
                chk("stride oldest", 512'(mag_b[0]), 512'(5));
            end
        end

        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, tbl[i].d);
            chk($sformatf("sm mag %0d", tbl[i].d), 512'(mag_a[48]), 512'(tbl[i].mag));
            chk($sformatf("sm pol %0d", tbl[i].d), 512'(pol_a[48]), 512'(tbl[i].pol));
        end

        drive(1, 0, 0, 0);
        repeat (30) drive(0, 0, 1, $urandom_range(0, 127));
        drive(0, 1, 1, 9);
        chk("flush mag", 512'(mag_a), '0);
        chk("flush pol", 512'(pol_a), '0);
        repeat (48) drive(0, 0, 1, $urandom_range(0, 127));
        chk("flush 48 fv", 512'(fv_a), '0);
        drive(0, 0, 1, $urandom_range(0, 127));
        chk("flush 49 fv", 512'(fv_a), 512'(1));

        drive(1, 0, 0, 0);
        repeat (48) drive(0, 0, 1, $urandom_range(0, 127));
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 1, $urandom_range(0, 127));
            chk("wrap fv", 512'(fv_c), 512'(1));
            chk($sformatf("wrap idx %0d", k), 512'(fi_c), 512'(k % 4));
        end
        repeat (7) drive(0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0);
            chk("wrap y run", 512'(yv_c), 512'(1));
        end
        drive(0, 0, 0, 0);
        chk("wrap y end", 512'(yv_c), '0);

        drive(1, 0, 0, 0);
        repeat (D) drive(0, 0, 1, $urandom_range(0, 127));
        chk("rst frame", 512'(fv_a), 512'(1));
        repeat (5) drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("rst mag", 512'(mag_a), '0);
        chk("rst pol", 512'(pol_a), '0);
        chk("rst fv", 512'(fv_a), '0);
        chk("rst idx", 512'(fi_a), '0);
        for (int k = 0; k < 15; k++) begin
            drive(0, 0, 0, 0);
            chk("rst y dropped", 512'(yv_a), '0);
        end

        repeat (600) drive($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
                           $urandom_range(0, 9) < 7, $urandom_range(0, 127));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
